// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared FSM states, engine mode codes and page-program constants
package spi_flash_pkg;

    // Control FSM: owns the request/busy/finish handshake with the arbiter and engine.
    typedef enum logic [1:0] {
        IDLE,
        EX_REQ,
        REQ_EXEC,
        REQ_FSH
    } ctrl_state_t;

    // Data FSM: sequences header bytes, then streams the page payload.
    typedef enum logic [2:0] {
        DIDLE,
        SEND_CMD,
        SEND_ADDR0,
        SEND_ADDR1,
        SEND_ADDR2,
        SEND_DATA,
        SEND_FSH
    } data_state_t;

    // SPI engine mode codes.
    localparam logic [2:0] SPI_MODE_WR = 3'b001;
    localparam logic [2:0] SPI_MODE_RD = 3'b010;

    // Default page-program opcodes for single and quad lanes.
    localparam logic [7:0] PP_CMD_X1_DEF = 8'h02;
    localparam logic [7:0] PP_CMD_X4_DEF = 8'h32;

    localparam int PAGE_BYTES = 256;
    localparam int HDR_BYTES  = 4;

endpackage

// File: rtl/spi_pp_data_feed.sv
// rtl/spi_pp_data_feed.sv - one-entry holding register and page byte counter
//
// Ports:
//   clock, rst_n      : clock, asynchronous active-low reset
//   clear_i           : start of a new page, empties holding register and zeroes counter
//   flush_i           : abort, empties holding register (counter kept for error check)
//   enable_i          : data FSM is in the payload phase
//   engine_ready_i    : engine ready and byte slot enabled this cycle
//   in_valid_i/in_data_i/in_ready_o : page-data input stream
//   hold_full_o/hold_data_o          : holding register towards the engine
//   accept_o          : engine takes the held byte this cycle
//   byte_cnt_o        : accepted payload bytes, 0..256
module spi_pp_data_feed
    import spi_flash_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             flush_i,
    input  logic             enable_i,
    input  logic             engine_ready_i,
    input  logic             in_valid_i,
    input  logic [DSIZE-1:0] in_data_i,
    output logic             in_ready_o,
    output logic             hold_full_o,
    output logic [DSIZE-1:0] hold_data_o,
    output logic             accept_o,
    output logic [8:0]       byte_cnt_o
);

    logic             full_q;
    logic [DSIZE-1:0] hold_q;
    logic [8:0]       cnt_q;
    logic [9:0]       loaded;
    logic             load;

    assign accept_o = enable_i && full_q && engine_ready_i;

    // Bytes already pulled from the stream this page: sent plus the one held.
    assign loaded = {1'b0, cnt_q} + {9'd0, full_q};

    // Pass-through when the held byte leaves this cycle; never pull byte 257.
    assign in_ready_o = enable_i && !flush_i && (loaded < 10'(PAGE_BYTES))
                        && (!full_q || accept_o);
    assign load = in_valid_i && in_ready_o;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            hold_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            full_q <= 1'b0;
            hold_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else begin
            if (accept_o) begin
                cnt_q <= cnt_q + 9'd1;
            end
            if (load) begin
                hold_q <= in_data_i;
                full_q <= 1'b1;
            end else if (accept_o) begin
                full_q <= 1'b0;
            end
        end
    end

    assign hold_full_o = full_q;
    assign hold_data_o = hold_q;
    assign byte_cnt_o  = cnt_q;

endmodule

// File: rtl/spi_page_program.sv
// rtl/spi_page_program.sv - flash page-program command: header plus 256-byte payload to the SPI engine
//
// Ports:
//   clock, rst_n                         : clock, asynchronous active-low reset
//   cmd_request/cmd_cmd/cmd_busy/cmd_finish/cmd_err : command arbiter interface
//   wr_addr                              : flash byte address, latched at command accept
//   spi_request/spi_busy/spi_req_*       : engine transaction request
//   spi_wr_vld/spi_wr_ready/spi_clk_en/spi_wr_data : engine byte interface
//   in_valid/in_data/in_ready            : page-data input stream
module spi_page_program
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] CMD       = 8'd1,
    parameter int          SSIZE     = 1,
    parameter int          DSIZE     = 8,
    parameter logic [7:0]  PP_CMD_X1 = PP_CMD_X1_DEF,
    parameter logic [7:0]  PP_CMD_X4 = PP_CMD_X4_DEF
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               cmd_request,
    input  logic [7:0]         cmd_cmd,
    output logic               cmd_busy,
    output logic               cmd_finish,
    output logic               cmd_err,
    input  logic [3*DSIZE-1:0] wr_addr,
    output logic               spi_request,
    input  logic               spi_busy,
    output logic [23:0]        spi_req_len,
    output logic [23:0]        spi_req_wr_len,
    output logic [2:0]         spi_req_cmd,
    output logic               spi_wr_vld,
    input  logic               spi_wr_ready,
    input  logic               spi_clk_en,
    output logic [DSIZE-1:0]   spi_wr_data,
    input  logic               in_valid,
    input  logic [DSIZE-1:0]   in_data,
    output logic               in_ready
);

    localparam logic [23:0] REQ_LEN = 24'((PAGE_BYTES + HDR_BYTES) * DSIZE / SSIZE);
    localparam logic [DSIZE-1:0] PP_CMD = (SSIZE == 1) ? DSIZE'(PP_CMD_X1) : DSIZE'(PP_CMD_X4);

    ctrl_state_t        ctrl_q, ctrl_d;
    data_state_t        dstate_q, dstate_d;
    logic               spi_request_q, busy_q, finish_q, err_q, exec_start_q;
    logic [3*DSIZE-1:0] addr_q;

    logic               in_exec, req_accept, abort, eng_accept;
    logic               feed_clear, feed_en, feed_accept, hold_full;
    logic [DSIZE-1:0]   hold_data;
    logic [8:0]         byte_cnt;

    assign spi_req_len    = REQ_LEN;
    assign spi_req_wr_len = REQ_LEN;
    assign spi_req_cmd    = SPI_MODE_WR;

    assign in_exec    = (ctrl_q == REQ_EXEC);
    assign req_accept = (ctrl_q == IDLE) && (ctrl_d == EX_REQ);
    // Engine finished before the full page went out: underrun or external abort.
    assign abort      = in_exec && !spi_busy && (byte_cnt < 9'(PAGE_BYTES));
    assign eng_accept = spi_wr_vld && spi_wr_ready && spi_clk_en;

    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            IDLE:     if (cmd_request && cmd_cmd == CMD) ctrl_d = EX_REQ;
            EX_REQ:   if (spi_busy) ctrl_d = REQ_EXEC;
            REQ_EXEC: if (!spi_busy) ctrl_d = REQ_FSH;
            REQ_FSH:  ctrl_d = IDLE;
            default:  ctrl_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q        <= IDLE;
            spi_request_q <= 1'b0;
            busy_q        <= 1'b0;
            finish_q      <= 1'b0;
            err_q         <= 1'b0;
            exec_start_q  <= 1'b0;
            addr_q        <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            spi_request_q <= (ctrl_d == EX_REQ);
            busy_q        <= (ctrl_d == EX_REQ) || (ctrl_d == REQ_EXEC);
            finish_q      <= (ctrl_d == REQ_FSH);
            // High for the first cycle of REQ_EXEC only, so the data FSM starts once per command.
            exec_start_q  <= (ctrl_q != REQ_EXEC) && (ctrl_d == REQ_EXEC);
            if (req_accept) begin
                addr_q <= wr_addr;
                err_q  <= 1'b0;
            end else if (abort) begin
                err_q  <= 1'b1;
            end
        end
    end

    assign spi_request = spi_request_q;
    assign cmd_busy    = busy_q;
    assign cmd_finish  = finish_q;
    assign cmd_err     = err_q;

    always_comb begin
        dstate_d = dstate_q;
        case (dstate_q)
            DIDLE:      if (exec_start_q) dstate_d = SEND_CMD;
            SEND_CMD:   if (!in_exec) dstate_d = SEND_FSH; else if (eng_accept) dstate_d = SEND_ADDR0;
            SEND_ADDR0: if (!in_exec) dstate_d = SEND_FSH; else if (eng_accept) dstate_d = SEND_ADDR1;
            SEND_ADDR1: if (!in_exec) dstate_d = SEND_FSH; else if (eng_accept) dstate_d = SEND_ADDR2;
            SEND_ADDR2: if (!in_exec) dstate_d = SEND_FSH; else if (eng_accept) dstate_d = SEND_DATA;
            SEND_DATA:  if (!in_exec || (feed_accept && byte_cnt == 9'(PAGE_BYTES - 1)))
                            dstate_d = SEND_FSH;
            SEND_FSH:   dstate_d = DIDLE;
            default:    dstate_d = DIDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            dstate_q <= DIDLE;
        end else begin
            dstate_q <= dstate_d;
        end
    end

    always_comb begin
        spi_wr_vld  = 1'b0;
        spi_wr_data = '0;
        case (dstate_q)
            SEND_CMD:   begin spi_wr_vld = 1'b1; spi_wr_data = PP_CMD;                     end
            SEND_ADDR0: begin spi_wr_vld = 1'b1; spi_wr_data = addr_q[3*DSIZE-1 -: DSIZE]; end
            SEND_ADDR1: begin spi_wr_vld = 1'b1; spi_wr_data = addr_q[2*DSIZE-1 -: DSIZE]; end
            SEND_ADDR2: begin spi_wr_vld = 1'b1; spi_wr_data = addr_q[DSIZE-1:0];          end
            SEND_DATA:  if (hold_full) begin spi_wr_vld = 1'b1; spi_wr_data = hold_data;   end
            default:    ;
        endcase
    end

    // Counter is cleared when a page starts, not on return to DIDLE, so the
    // abort check still sees 256 if the engine drops busy late.
    assign feed_clear = (dstate_q == DIDLE) && exec_start_q;
    assign feed_en    = (dstate_q == SEND_DATA);

    spi_pp_data_feed #(
        .DSIZE (DSIZE)
    ) u_feed (
        .clock          (clock),
        .rst_n          (rst_n),
        .clear_i        (feed_clear),
        .flush_i        (abort),
        .enable_i       (feed_en),
        .engine_ready_i (spi_wr_ready && spi_clk_en),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (in_ready),
        .hold_full_o    (hold_full),
        .hold_data_o    (hold_data),
        .accept_o       (feed_accept),
        .byte_cnt_o     (byte_cnt)
    );

endmodule

// File: tb/tb_spi_page_program.sv
// tb/tb_spi_page_program.sv - self-checking bench for spi_page_program
module tb_spi_page_program;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n, cmd_request, spi_busy, spi_wr_ready, spi_clk_en, in_valid;
    logic [7:0]  cmd_cmd, in_data;
    logic [23:0] wr_addr;

    logic        cmd_busy, cmd_finish, cmd_err, spi_request, spi_wr_vld, in_ready;
    logic [23:0] spi_req_len, spi_req_wr_len;
    logic [2:0]  spi_req_cmd;
    logic [7:0]  spi_wr_data;

    logic        d4_busy, d4_finish, d4_err, d4_request, d4_vld, d4_in_ready;
    logic [23:0] d4_len, d4_wr_len;
    logic [2:0]  d4_cmd;
    logic [7:0]  d4_data;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  d4_first;

    spi_page_program u_dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .cmd_request    (cmd_request),
        .cmd_cmd        (cmd_cmd),
        .cmd_busy       (cmd_busy),
        .cmd_finish     (cmd_finish),
        .cmd_err        (cmd_err),
        .wr_addr        (wr_addr),
        .spi_request    (spi_request),
        .spi_busy       (spi_busy),
        .spi_req_len    (spi_req_len),
        .spi_req_wr_len (spi_req_wr_len),
        .spi_req_cmd    (spi_req_cmd),
        .spi_wr_vld     (spi_wr_vld),
        .spi_wr_ready   (spi_wr_ready),
        .spi_clk_en     (spi_clk_en),
        .spi_wr_data    (spi_wr_data),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready)
    );

    spi_page_program #(.SSIZE(4)) u_dut4 (
        .clock          (clock),
        .rst_n          (rst_n),
        .cmd_request    (cmd_request),
        .cmd_cmd        (cmd_cmd),
        .cmd_busy       (d4_busy),
        .cmd_finish     (d4_finish),
        .cmd_err        (d4_err),
        .wr_addr        (wr_addr),
        .spi_request    (d4_request),
        .spi_busy       (spi_busy),
        .spi_req_len    (d4_len),
        .spi_req_wr_len (d4_wr_len),
        .spi_req_cmd    (d4_cmd),
        .spi_wr_vld     (d4_vld),
        .spi_wr_ready   (spi_wr_ready),
        .spi_clk_en     (spi_clk_en),
        .spi_wr_data    (d4_data),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (d4_in_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string phase);
        chk({phase, "_spi_request"}, spi_request, 0);
        chk({phase, "_cmd_busy"},    cmd_busy,    0);
        chk({phase, "_cmd_finish"},  cmd_finish,  0);
        chk({phase, "_cmd_err"},     cmd_err,     0);
        chk({phase, "_spi_wr_vld"},  spi_wr_vld,  0);
        chk({phase, "_in_ready"},    in_ready,    0);
        chk({phase, "_spi_wr_data"}, spi_wr_data, 0);
    endtask

    // Drives one page-program command through an engine/source model and
    // compares the engine-side byte stream with opcode + address + payload.
    task automatic do_page(input logic [23:0] addr, input bit ordered, input bit gap,
                           input bit rand_hs, input int abort_at, input int reset_at);
        logic [7:0] src[256];
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        int  taken, fin, post, gap_i, cyc, mism, n;
        bit  started, ended, rdy_chk, d4_seen, in_gap;
        taken = 0; fin = 0; post = 0; gap_i = 0; cyc = 0; mism = 0;
        started = 0; ended = 0; rdy_chk = 0; d4_seen = 0;
        for (int i = 0; i < 256; i++) src[i] = ordered ? 8'(i) : 8'($urandom);
        exp_q.push_back(8'h02);
        exp_q.push_back(addr[23:16]);
        exp_q.push_back(addr[15:8]);
        exp_q.push_back(addr[7:0]);
        for (int i = 0; i < 256; i++) exp_q.push_back(src[i]);

        cmd_cmd = 8'd1; wr_addr = addr; cmd_request = 1'b1;
        @(posedge clock); #1;
        cmd_request = 1'b0;
        wr_addr = ~addr;
        chk("req_cmd_busy", cmd_busy, 1);
        chk("req_spi_request", spi_request, 1);
        chk("req_err_cleared", cmd_err, 0);

        while (cyc < 8000) begin
            cyc++;
            if (!started && spi_request) begin spi_busy = 1'b1; started = 1; end
            if (started && !ended && (got_q.size() == 260 ||
                (abort_at >= 0 && got_q.size() == 4 + abort_at))) begin
                spi_busy = 1'b0; ended = 1;
            end
            if (reset_at >= 0 && got_q.size() == 4 + reset_at) begin
                rst_n = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                spi_busy = 1'b0; spi_wr_ready = 1'b0; spi_clk_en = 1'b0; in_valid = 1'b0;
                repeat (2) @(posedge clock);
                #1 rst_n = 1'b1;
                @(posedge clock); #1;
                chk_all_zero("rst_after");
                return;
            end
            spi_wr_ready = ended ? 1'b0 : (rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1);
            spi_clk_en   = ended ? 1'b0 : (rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_valid     = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_gap = 0;
            if (gap && taken == 100 && gap_i < 10) begin in_valid = 1'b0; gap_i++; in_gap = 1; end
            in_data = (taken < 256) ? src[taken] : 8'($urandom);

            @(negedge clock);
            if (in_gap && gap_i >= 2) chk("gap_vld_low", spi_wr_vld, 0);
            if (!spi_wr_vld) chk("data_zero_when_idle", spi_wr_data, 0);
            if (spi_wr_vld && spi_wr_ready && spi_clk_en) got_q.push_back(spi_wr_data);
            if (!d4_seen && d4_vld && spi_wr_ready && spi_clk_en) begin
                d4_seen = 1; d4_first = d4_data;
            end
            if (taken == 256 && in_valid && !rdy_chk) begin
                rdy_chk = 1;
                chk("in_ready_after_256", in_ready, 0);
            end
            if (in_valid && in_ready) taken++;
            if (cmd_finish) fin++;
            @(posedge clock); #1;
            if (ended && fin > 0) post++;
            if (post == 4) break;
        end

        chk("page_in_time", cyc < 8000, 1);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mism++;
        chk("stream_bytes_match", mism, 0);
        chk("finish_once", fin, 1);
        chk("back_idle", cmd_busy, 0);
        if (abort_at >= 0) begin
            chk("abort_bytes", got_q.size(), 4 + abort_at);
            chk("abort_err", cmd_err, 1);
        end else begin
            chk("page_bytes", got_q.size(), 260);
            chk("src_taken", taken, 256);
            chk("page_err", cmd_err, 0);
        end
        spi_wr_ready = 1'b0; spi_clk_en = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_request = 1'b0; cmd_cmd = 8'd0; wr_addr = '0;
        spi_busy = 1'b0; spi_wr_ready = 1'b0; spi_clk_en = 1'b0;
        in_valid = 1'b0; in_data = 8'd0; d4_first = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clock); #1;
        chk("req_len_x1", spi_req_len, 2080);
        chk("req_wr_len_x1", spi_req_wr_len, 2080);
        chk("req_cmd", spi_req_cmd, 3'b001);
        chk("req_len_x4", d4_len, 520);
        chk("req_wr_len_x4", d4_wr_len, 520);

        do_page(24'h123400, 1, 0, 0, -1, -1);
        chk("x4_opcode", d4_first, 8'h32);

        do_page(24'($urandom), 0, 1, 0, -1, -1);
        repeat (2) do_page(24'($urandom), 0, 0, 1, -1, -1);

        cmd_cmd = 8'd2; cmd_request = 1'b1;
        @(posedge clock); #1;
        cmd_request = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("cmd2_no_request", spi_request, 0);
            chk("cmd2_not_busy", cmd_busy, 0);
            @(posedge clock); #1;
        end

        do_page(24'($urandom), 0, 0, 1, 50, -1);
        do_page(24'($urandom), 0, 0, 0, -1, -1);

        do_page(24'($urandom), 0, 0, 1, -1, 128);
        do_page(24'($urandom), 0, 0, 1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
